// File: rtl/lab3_encoder_8to3.sv
// lab3_encoder_8to3: latches request pulses and hands out one pending index at a time over valid/ready.
// Define LAB3_ENC_ROUND_ROBIN_EN for round-robin selection; fixed highest-index priority otherwise.
module lab3_encoder_8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] idx,
    output logic [7:0] pending,
    output logic       overrun
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state_q, state_d;
    logic [7:0] pending_q, pending_d, clr;
    logic [2:0] idx_q, idx_d, sel;
    logic valid_q, valid_d, overrun_q, overrun_d, hs;
    assign hs = valid_q && ready;
    assign clr = hs ? 8'(1) << idx_q : '0;
    // a request landing on the bit being acked re-arms it instead of counting as an overrun
    assign pending_d = (pending_q & ~clr) | req;
    assign overrun_d = |(req & pending_q & ~clr);
`ifdef LAB3_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr_q, cand;
    always_comb begin
        sel = '0;
        cand = '0;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr_q + 3'(k);
            if (pending_q[cand]) sel = cand;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= 3'd7;
        else if (hs) ptr_q <= idx_q;
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < 8; i++)
            if (pending_q[i]) sel = 3'(i);
    end
`endif
    // selection only happens in IDLE, so a presented index is never preempted
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        valid_d = valid_q;
        if (state_q == IDLE) begin
            valid_d = 1'b0;
            if (pending_q != '0) begin
                idx_d = sel;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
        end else if (ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pending_q <= '0;
            idx_q <= '0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            idx_q <= idx_d;
            valid_q <= valid_d;
            overrun_q <= overrun_d;
        end
    end
    assign valid = valid_q;
    assign idx = idx_q;
    assign pending = pending_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_lab3_encoder_8to3.sv
// tb_lab3_encoder_8to3: directed and random stimulus against a behavioural model of the encoder.
module tb_lab3_encoder_8to3;
    logic clk = 1'b0;
    logic rst_n, ready, valid, overrun;
    logic [7:0] req, pending;
    logic [2:0] idx;
    int n_chk = 0, n_err = 0, n_ovr;
    bit [7:0] m_pend, or_req, or_dec;
    bit m_valid, m_ovr;
    bit [2:0] m_idx, m_ptr;
    int grants[$];

    lab3_encoder_8to3 dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .valid(valid), .idx(idx), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [2:0] pick(input bit [7:0] p, input bit [2:0] ptr);
`ifdef LAB3_ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++)
            if (p[(int'(ptr) + k) % 8]) return 3'((int'(ptr) + k) % 8);
`else
        for (int i = 7; i >= 0; i--)
            if (p[i]) return 3'(i);
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_valid = 0; m_ovr = 0; m_idx = 0; m_ptr = 3'd7;
        or_req = 0; or_dec = 0;
    endtask

    task automatic model_edge(input bit [7:0] r, input bit rdy);
        bit ack;
        bit [7:0] old_pend, clr;
        ack = m_valid && rdy;
        clr = 0;
        if (ack) clr[m_idx] = 1'b1;
        old_pend = m_pend;
        m_ovr = (r & m_pend & ~clr) != 0;
        m_pend = (m_pend & ~clr) | r;
        if (m_valid) begin
            if (rdy) begin m_valid = 0; m_ptr = m_idx; end
        end else if (old_pend != 0) begin
            m_idx = pick(old_pend, m_ptr);
            m_valid = 1;
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(valid), 32'(m_valid));
        chk("idx", 32'(idx), 32'(m_idx));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // called at a falling edge: drive, take the rising edge, compare at the next falling edge
    task automatic step(input logic [7:0] r, input logic rdy);
        req = r;
        ready = rdy;
        if (valid && rdy) begin
            grants.push_back(int'(idx));
            or_dec[idx] = 1'b1;
        end
        or_req |= r;
        @(posedge clk);
        model_edge(r, rdy);
        @(negedge clk);
        if (overrun) n_ovr++;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req = '0; ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        step(8'h20, 1'b1);
        chk("single_pend", 32'(pending), 32'h20);
        step(8'h00, 1'b1);
        chk("single_idx", 32'(idx), 32'd5);
        chk("single_valid", 32'(valid), 32'd1);
        step(8'h00, 1'b1);
        chk("single_drop", 32'(valid), 32'd0);
        chk("single_empty", 32'(pending), 32'd0);

        grants = {};
        step(8'h81, 1'b1);
        repeat (5) step(8'h00, 1'b1);
        chk("prio_count", 32'(grants.size()), 32'd2);
`ifdef LAB3_ENC_ROUND_ROBIN_EN
        chk("prio_first", 32'(grants[0]), 32'd0);
        chk("prio_second", 32'(grants[1]), 32'd7);
`else
        chk("prio_first", 32'(grants[0]), 32'd7);
        chk("prio_second", 32'(grants[1]), 32'd0);
`endif

        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        step(8'h80, 1'b0);
        repeat (3) step(8'h00, 1'b0);
        chk("bp_hold_idx", 32'(idx), 32'd2);
        chk("bp_hold_valid", 32'(valid), 32'd1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("bp_next_idx", 32'(idx), 32'd7);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        n_ovr = 0;
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        step(8'h00, 1'b0);
        chk("ovr_pulses", 32'(n_ovr), 32'd2);
        chk("ovr_presented", 32'(idx), 32'd3);
        step(8'h08, 1'b1);
        chk("setwins_pend", 32'(pending[3]), 32'd1);
        chk("setwins_ovr", 32'(overrun), 32'd0);
        step(8'h00, 1'b1);
        chk("setwins_regrant", 32'({valid, idx}), 32'({1'b1, 3'd3}));
        step(8'h00, 1'b1);

        repeat (3) step(8'hFF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_idx", 32'(idx), 32'd0);
        chk("async_pend", 32'(pending), 32'd0);
        chk("async_ovr", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;

        for (int c = 0; c < 500; c++)
            step(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 1'($urandom_range(0, 1)));
        repeat (20) step(8'h00, 1'b1);
        chk("rt_drained", 32'(pending), 32'd0);
        chk("rt_or", 32'(or_dec), 32'(or_req));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
